// File: rtl/ll_rx_credit_ctrl.sv
// RX link control: gates user_i_valid on FIFO state and stores pops as pending credits.
// Optional credit over/underflow checking is enabled by defining LL_RX_CREDIT_OVF_CHK_EN.
module ll_rx_credit_ctrl #(
    parameter int FIFO_COUNT_MSB  = 4,
    parameter int CREDIT_CNT_MSB  = 4,
    parameter int CREDIT_HOLD_MAX = 31
) (
    input  logic                    clk_wr,
    input  logic                    rst_wr_n,
    output logic                    user_i_valid,
    input  logic                    user_i_ready,
    output logic                    rxfifo_i_pop,
    input  logic                    rxfifo_i_empty,
    input  logic [FIFO_COUNT_MSB:0] dbg_rxfifo_i_numfilled,
    input  logic                    rxfifo_i_push,
    input  logic                    tx_online,
    output logic                    tx_i_credit,
    output logic [CREDIT_CNT_MSB:0] credit_pend,
    output logic                    credit_ovf_err
);

    localparam int FW = FIFO_COUNT_MSB + 1;
    localparam int CW = CREDIT_CNT_MSB + 1;
    localparam logic [CW-1:0] HOLD = CW'(CREDIT_HOLD_MAX);
    localparam logic [FW-1:0] ONE  = FW'(1);

    logic          corner_q, corner_d;
    logic          empty_dly_q;
    logic [CW-1:0] credit_pend_q, credit_pend_d;
    logic          tx_credit_q, tx_credit_d;
    logic          hold_full;

    assign hold_full    = (credit_pend_q >= HOLD) & ~tx_online;
    assign user_i_valid = ~rxfifo_i_empty & ~empty_dly_q
                        & ~corner_q & ~hold_full;
    assign rxfifo_i_pop = user_i_valid & user_i_ready;
    assign tx_i_credit  = tx_credit_q & tx_online;
    assign credit_pend  = credit_pend_q;

    // RAM read latency: a lone entry popped while refilled is not yet readable
    assign corner_d = rxfifo_i_push & rxfifo_i_pop
                    & (dbg_rxfifo_i_numfilled == ONE);

    assign credit_pend_d = credit_pend_q + CW'(rxfifo_i_pop)
                         - CW'(tx_i_credit);
    assign tx_credit_d   = tx_online & (credit_pend_d != '0);

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            corner_q      <= 1'b0;
            empty_dly_q   <= 1'b1;
            credit_pend_q <= '0;
            tx_credit_q   <= 1'b0;
        end else begin
            corner_q      <= corner_d;
            empty_dly_q   <= rxfifo_i_empty;
            credit_pend_q <= credit_pend_d;
            tx_credit_q   <= tx_credit_d;
        end
    end

`ifdef LL_RX_CREDIT_OVF_CHK_EN
    logic ovf_q, ovf_cond;

    assign ovf_cond = (rxfifo_i_pop & (&credit_pend_q))
                    | (tx_i_credit & (credit_pend_q == '0));
    assign credit_ovf_err = ovf_q;

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | ovf_cond;
        end
    end

    if (CREDIT_HOLD_MAX > (2 ** CW) - 1) begin : g_hold_chk
        $error("CREDIT_HOLD_MAX exceeds credit counter capacity");
    end

`ifndef SYNTHESIS
    always @(posedge clk_wr) begin
        if (rst_wr_n) begin
            assert (!ovf_cond)
                else $error("credit counter over/underflow");
        end
    end
`endif
`else
    assign credit_ovf_err = 1'b0;
`endif

endmodule
